// File: rtl/counter_pkg.sv
// Shared definitions for the cascaded digit counter.
// Holds the clock-style terminal constants, the direction encoding and the
// helper that extracts one digit field from a packed multi-digit vector.
package counter_pkg;

    // Widest packed vector and widest digit field the helper can handle.
    localparam int unsigned VEC_MAX_W   = 256;
    localparam int unsigned FIELD_MAX_W = 32;

    // BCD-style terminal values for a time-of-day display.
    localparam logic [7:0] MAXV_SEC_MIN = {4'd5, 4'd9};  // seconds / minutes: 59
    localparam logic [7:0] MAXV_HOURS   = {4'd2, 4'd3};  // hours: 23
    localparam logic [7:0] DEFAULT_MAXV = MAXV_SEC_MIN;

    // Counting direction as seen on the up_down input.
    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Return field idx (each w bits wide) of a packed vector.
    // Callers zero-extend their vector to VEC_MAX_W bits and truncate the result to w bits.
    function automatic logic [FIELD_MAX_W-1:0] digit_field(
        input logic [VEC_MAX_W-1:0] vec,
        input int unsigned          idx,
        input int unsigned          w
    );
        logic [VEC_MAX_W-1:0] shifted;
        logic [VEC_MAX_W-1:0] mask;
        shifted = vec >> (idx * w);
        mask    = (VEC_MAX_W'(1) << w) - VEC_MAX_W'(1);
        return FIELD_MAX_W'(shifted & mask);
    endfunction

endpackage

// File: rtl/mod_digit.sv
// One W-bit modulo up/down digit.
// It counts between 0 and MAXV_D inclusive and wraps at either end.
// A load is clamped to MAXV_D. The terminal output flags the wrap point
// for the current direction, so the chain can build its ripple-enable from it.
module mod_digit
    import counter_pkg::*;
#(
    parameter int unsigned W      = 4,
    parameter logic [W-1:0] MAXV_D = W'(9)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         step,
    input  logic         up_down,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         terminal
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Terminal flag: at the top when counting up, at zero when counting down.
    always_comb begin
        if (dir_e'(up_down) == DIR_UP) begin
            terminal = (count_q == MAXV_D);
        end else begin
            terminal = (count_q == '0);
        end
    end

    // Next-value selection: load (clamped) beats step; otherwise hold.
    always_comb begin
        // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
        count_d = count_q;
        if (load) begin
            count_d = (load_val > MAXV_D) ? MAXV_D : load_val;
        end else if (step) begin
            if (dir_e'(up_down) == DIR_UP) begin
                count_d = (count_q == MAXV_D) ? '0 : count_q + W'(1);
            end else begin
                count_d = (count_q == '0) ? MAXV_D : count_q - W'(1);
            end
        end
    end

    // Digit register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge values.
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/digit_chain_counter.sv
// Cascade of NDIG modulo up/down digits that all share one clock.
// Each digit steps when en is high and every lower digit sits at its terminal.
// All steps come from the same pre-edge values, so a full carry ripples in one cycle.
// carry_out is combinational so further chains can cascade off it.
// rollover is a registered pulse that follows a whole-chain wrap.
// Build option: define CNT_SATURATE_EN to make the chain hold at its terminal instead of
// wrapping. In that build rollover never pulses. The port list is identical in both builds.
module digit_chain_counter
    import counter_pkg::*;
#(
    parameter int unsigned          W    = 4,
    parameter int unsigned          NDIG = 2,
    parameter logic [NDIG*W-1:0]    MAXV = DEFAULT_MAXV
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              up_down,
    input  logic              load,
    input  logic [NDIG*W-1:0] load_val,
    output logic [NDIG*W-1:0] count,
    output logic              carry_out,
    output logic              rollover
);

    logic [NDIG-1:0] term;
    logic [NDIG-1:0] step;
    logic            all_term;
    logic            rollover_q;
    logic            rollover_d;

    // Whole-chain terminal detect; drives carry_out independently of load/reset.
    always_comb begin
        all_term  = &term;
        carry_out = en & all_term;
    end

    // Ripple enable: digit i steps when en is high and all lower digits are at terminal.
    always_comb begin : step_gen
        logic below_term;
        below_term = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
`ifdef CNT_SATURATE_EN
            // Holding at terminal: suppress every step while the chain would wrap.
            step[i] = en & below_term & ~carry_out;
`else
            step[i] = en & below_term;
`endif
            below_term = below_term & term[i];
        end
    end

    // Rollover follows an edge on which the chain actually wrapped (load wins over wrap).
    always_comb begin
`ifdef CNT_SATURATE_EN
        rollover_d = 1'b0;
`else
        rollover_d = carry_out & ~load;
`endif
    end

    // Rollover pulse register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rollover_q <= 1'b0;
        end else begin
            rollover_q <= rollover_d;
        end
    end

    assign rollover = rollover_q;

    for (genvar i = 0; i < NDIG; i++) begin : g_digit
        localparam logic [W-1:0] DIGIT_MAXV =
            W'(digit_field(VEC_MAX_W'(MAXV), i, W));

        mod_digit #(
            .W      (W),
            .MAXV_D (DIGIT_MAXV)
        ) u_digit (
            .clk      (clk),
            .reset    (reset),
            .step     (step[i]),
            .up_down  (up_down),
            .load     (load),
            .load_val (load_val[i*W +: W]),
            .count    (count[i*W +: W]),
            .terminal (term[i])
        );
    end

endmodule

// File: tb/tb_digit_chain_counter.sv
// Directed-vector bench for digit_chain_counter with W=4, NDIG=2, MAXV=59.
// The driver applies one row per cycle and queues the outputs expected during that cycle.
// A monitor on the falling edge pops the queue and compares.
module tb_digit_chain_counter;

`ifdef CNT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        string      name;
        logic [7:0] count;
        logic       carry;
        logic       roll;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up_down;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       carry_out;
    logic       rollover;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    digit_chain_counter #(
        .W    (4),
        .NDIG (2),
        .MAXV ({4'd5, 4'd9})
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .up_down   (up_down),
        .load      (load),
        .load_val  (load_val),
        .count     (count),
        .carry_out (carry_out),
        .rollover  (rollover)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, ".count"},    count,            e.count);
            check({e.name, ".carry"},    {7'd0, carry_out}, {7'd0, e.carry});
            check({e.name, ".rollover"}, {7'd0, rollover},  {7'd0, e.roll});
        end
    end

    // Drive one cycle of inputs, queue the expected outputs for that cycle, advance.
    task automatic cyc(input string nm, input logic r, input logic ld, input logic [7:0] lv,
                       input logic e, input logic ud,
                       input logic [7:0] ec, input logic ecar, input logic er);
        exp_t x;
        reset    = r;
        load     = ld;
        load_val = lv;
        en       = e;
        up_down  = ud;
        x.name   = nm;
        x.count  = ec;
        x.carry  = ecar;
        x.roll   = er;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; load_val = 8'h00; en = 1'b0; up_down = 1'b1;
        @(posedge clk);
        #1;
        //   name          rst ld lv     en ud  count                 carry            roll
        cyc("rst_hold",    1, 0, 8'h00, 0, 1, 8'h00,                 0,               0);
        // Up wrap from 59
        cyc("load59",      0, 1, 8'h59, 1, 1, 8'h00,                 0,               0);
        cyc("wrap_up",     0, 0, 8'h00, 1, 1, 8'h59,                 1,               0);
        cyc("after_wrap",  0, 0, 8'h00, 0, 1, SAT ? 8'h59 : 8'h00,   0,               SAT ? 1'b0 : 1'b1);
        cyc("roll_clear",  0, 0, 8'h00, 0, 1, SAT ? 8'h59 : 8'h00,   0,               0);
        // Down wrap from 00 after reset; carry_out ignores reset
        cyc("rst_down",    1, 0, 8'h00, 1, 0, SAT ? 8'h59 : 8'h00,   SAT ? 1'b0 : 1'b1, 0);
        cyc("wrap_down",   0, 0, 8'h00, 1, 0, 8'h00,                 1,               0);
        cyc("after_down",  0, 0, 8'h00, 0, 0, SAT ? 8'h00 : 8'h59,   0,               SAT ? 1'b0 : 1'b1);
        // Clamped load
        cyc("load00",      0, 1, 8'h00, 0, 1, SAT ? 8'h00 : 8'h59,   0,               0);
        cyc("clamp",       0, 1, 8'h7C, 0, 1, 8'h00,                 0,               0);
        cyc("clamp_chk",   0, 0, 8'h00, 0, 1, 8'h59,                 0,               0);
        // Count to 39, hold with en=0, then carry into the upper digit
        cyc("load37",      0, 1, 8'h37, 0, 1, 8'h59,                 0,               0);
        cyc("up37",        0, 0, 8'h00, 1, 1, 8'h37,                 0,               0);
        cyc("up38",        0, 0, 8'h00, 1, 1, 8'h38,                 0,               0);
        for (int i = 0; i < 5; i++) begin
            cyc($sformatf("hold39_%0d", i), 0, 0, 8'h00, 0, 1, 8'h39, 0, 0);
        end
        cyc("up39",        0, 0, 8'h00, 1, 1, 8'h39,                 0,               0);
        // Direction change takes effect on the same edge (borrow 40 -> 39)
        cyc("down40",      0, 0, 8'h00, 1, 0, 8'h40,                 0,               0);
        cyc("chk39",       0, 0, 8'h00, 0, 1, 8'h39,                 0,               0);
        // Priority: reset beats load, load beats en
        cyc("load24",      0, 1, 8'h24, 0, 1, 8'h39,                 0,               0);
        cyc("rst_ld",      1, 1, 8'h33, 1, 1, 8'h24,                 0,               0);
        cyc("ld_en",       0, 1, 8'h24, 1, 1, 8'h00,                 0,               0);
        cyc("ld59b",       0, 1, 8'h59, 0, 1, 8'h24,                 0,               0);
        // Load while carry_out=1: no wrap, so no rollover
        cyc("ld_at_term",  0, 1, 8'h12, 1, 1, 8'h59,                 1,               0);
        cyc("no_roll",     0, 0, 8'h00, 1, 1, 8'h12,                 0,               0);
        // Reset mid-count discards the step; counting resumes from 00
        cyc("rst_mid",     1, 0, 8'h00, 1, 1, 8'h13,                 0,               0);
        cyc("resume",      0, 0, 8'h00, 1, 1, 8'h00,                 0,               0);
        cyc("chk01",       0, 0, 8'h00, 0, 1, 8'h01,                 0,               0);
        // Three enabled cycles at 59: wrap (default) or hold (saturating build)
        cyc("ld59c",       0, 1, 8'h59, 0, 1, 8'h01,                 0,               0);
        cyc("term1",       0, 0, 8'h00, 1, 1, 8'h59,                 1,               0);
        cyc("term2",       0, 0, 8'h00, 1, 1, SAT ? 8'h59 : 8'h00,   SAT ? 1'b1 : 1'b0, SAT ? 1'b0 : 1'b1);
        cyc("term3",       0, 0, 8'h00, 1, 1, SAT ? 8'h59 : 8'h01,   SAT ? 1'b1 : 1'b0, 0);
        cyc("term_end",    0, 0, 8'h00, 0, 1, SAT ? 8'h59 : 8'h02,   0,               0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
